// File: rtl/test_controller_pkg.sv
//==============================================================================
// Module   : test_controller_pkg
// Purpose  : Shared types and constants for the phoeniX run controller.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package test_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_RESET_HOLD = 2'd1,
        ST_RUN        = 2'd2,
        ST_DONE       = 2'd3
    } state_t;

    // Bit 0 set marks an exit write; the remaining bits carry the exit code.
    localparam int unsigned c_exit_flag_bit = 0;

    localparam logic [31:0] c_tohost_addr_default = 32'h0000_1000;

endpackage

`default_nettype wire

// File: rtl/clock_enable_divider.sv
//==============================================================================
// Module   : clock_enable_divider
// Purpose  : Registered one-cycle tick every DIV enabled clocks.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module clock_enable_divider #(
    parameter int unsigned DIV = 6
) (
    input  logic CLK,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_tick;

    // The tick lands in the cycle after the counter reaches its last value.
    always_ff @(posedge CLK) begin
        if (reset || clear) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (enable) begin
            r_tick <= (r_cnt == c_last);
            r_cnt  <= (r_cnt == c_last) ? '0 : r_cnt + c_cnt_w'(1);
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule

`default_nettype wire

// File: rtl/test_controller.sv
//==============================================================================
// Module   : test_controller
// Purpose  : Core clock-enable, reset sequencing and tohost exit detection.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module test_controller
    import test_controller_pkg::*;
#(
    parameter int unsigned CLK_DIV        = 6,
    parameter int unsigned RESET_CYCLES   = 3,
    parameter int unsigned TIMEOUT_CYCLES = 120,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned CYCLE_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = ADDR_WIDTH'(c_tohost_addr_default)
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   mem_write_enable,
    input  logic [ADDR_WIDTH-1:0]  mem_address,
    input  logic [DATA_WIDTH-1:0]  mem_write_data,
    output logic                   core_clk_en,
    output logic                   core_reset,
    output logic [CYCLE_WIDTH-1:0] cycle_count,
    output logic                   done,
    output logic                   pass,
    output logic                   fail,
    output logic                   timeout,
    output logic [DATA_WIDTH-1:0]  exit_code
);

    // Reset hold is timed in fast cycles so it ends on the edge issuing the last hold tick.
    localparam int unsigned c_hold_total = CLK_DIV * RESET_CYCLES;
    localparam int unsigned c_hold_w     = $clog2(c_hold_total + 1);
    localparam logic [c_hold_w-1:0]    c_hold_last = c_hold_w'(c_hold_total - 1);
    localparam logic [CYCLE_WIDTH-1:0] c_timeout   = CYCLE_WIDTH'(TIMEOUT_CYCLES);

    state_t                 r_state, w_state_next;
    logic [c_hold_w-1:0]    r_hold_cnt, w_hold_cnt_next;
    logic [CYCLE_WIDTH-1:0] r_cycle_count, w_cycle_count_next, w_cycle_inc;
    logic                   r_core_reset, w_core_reset_next;
    logic                   r_done, w_done_next;
    logic                   r_pass, w_pass_next;
    logic                   r_fail, w_fail_next;
    logic                   r_timeout, w_timeout_next;
    logic [DATA_WIDTH-1:0]  r_exit_code, w_exit_code_next, w_exit_value;
    logic                   w_exit_write;
    logic                   w_div_clear;
    logic                   w_div_enable;
    logic                   w_tick;

    clock_enable_divider #(
        .DIV    (CLK_DIV)
    ) u_divider (
        .CLK    (CLK),
        .reset  (reset),
        .clear  (w_div_clear),
        .enable (w_div_enable),
        .tick   (w_tick)
    );

    assign w_exit_value = mem_write_data >> 1;
    assign w_cycle_inc  = (r_cycle_count == '1) ? r_cycle_count
                                                : r_cycle_count + CYCLE_WIDTH'(1);
    assign w_exit_write = (r_state == ST_RUN) && mem_write_enable && w_tick
                       && (mem_address == TOHOST_ADDR)
                       && mem_write_data[c_exit_flag_bit];

    always_comb begin
        w_state_next       = r_state;
        w_hold_cnt_next    = r_hold_cnt;
        w_cycle_count_next = r_cycle_count;
        w_done_next        = r_done;
        w_pass_next        = r_pass;
        w_fail_next        = r_fail;
        w_timeout_next     = r_timeout;
        w_exit_code_next   = r_exit_code;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_next       = ST_RESET_HOLD;
                    w_hold_cnt_next    = '0;
                    w_cycle_count_next = '0;
                    w_done_next        = 1'b0;
                    w_pass_next        = 1'b0;
                    w_fail_next        = 1'b0;
                    w_timeout_next     = 1'b0;
                    w_exit_code_next   = '0;
                end
            end
            ST_RESET_HOLD: begin
                w_hold_cnt_next = r_hold_cnt + c_hold_w'(1);
                if (r_hold_cnt == c_hold_last) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_tick) begin
                    w_cycle_count_next = w_cycle_inc;
                    // An exit write on the timeout tick takes precedence.
                    if (w_exit_write) begin
                        w_exit_code_next = w_exit_value;
                        w_pass_next      = (w_exit_value == '0);
                        w_fail_next      = (w_exit_value != '0);
                        w_done_next      = 1'b1;
                        w_state_next     = ST_DONE;
                    end else if (w_cycle_inc == c_timeout) begin
                        w_timeout_next = 1'b1;
                        w_done_next    = 1'b1;
                        w_state_next   = ST_DONE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        w_core_reset_next = (w_state_next == ST_IDLE) || (w_state_next == ST_RESET_HOLD);
    end

    // Divider restarts on run entry and stays cleared whenever the core is not ticking.
    assign w_div_enable = (r_state == ST_RESET_HOLD) || (r_state == ST_RUN);
    assign w_div_clear  = (w_state_next == ST_IDLE) || (w_state_next == ST_DONE)
                       || (((r_state == ST_IDLE) || (r_state == ST_DONE))
                           && (w_state_next == ST_RESET_HOLD));

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_hold_cnt    <= '0;
            r_cycle_count <= '0;
            r_core_reset  <= 1'b1;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
            r_timeout     <= 1'b0;
            r_exit_code   <= '0;
        end else begin
            r_state       <= w_state_next;
            r_hold_cnt    <= w_hold_cnt_next;
            r_cycle_count <= w_cycle_count_next;
            r_core_reset  <= w_core_reset_next;
            r_done        <= w_done_next;
            r_pass        <= w_pass_next;
            r_fail        <= w_fail_next;
            r_timeout     <= w_timeout_next;
            r_exit_code   <= w_exit_code_next;
        end
    end

    assign core_clk_en = w_tick;
    assign core_reset  = r_core_reset;
    assign cycle_count = r_cycle_count;
    assign done        = r_done;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign timeout     = r_timeout;
    assign exit_code   = r_exit_code;

endmodule

`default_nettype wire

// File: tb/tb_test_controller.sv
//==============================================================================
// Module   : tb_test_controller
// Purpose  : Scoreboard bench for test_controller run sequencing and exit detection.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_test_controller;

    localparam int unsigned c_div     = 6;
    localparam int unsigned c_rst     = 3;
    localparam int unsigned c_to      = 120;
    localparam logic [31:0] c_tohost  = 32'h0000_1000;
    localparam int          c_limit   = 2000;

    typedef struct packed {
        logic        pass;
        logic        fail;
        logic        timeout;
        logic [31:0] code;
        logic [31:0] cycles;
    } exp_t;

    logic        CLK = 1'b0;
    logic        reset;
    logic        start;
    logic        mem_write_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        core_clk_en;
    logic        core_reset;
    logic [31:0] cycle_count;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [31:0] exit_code;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    test_controller #(
        .CLK_DIV          (c_div),
        .RESET_CYCLES     (c_rst),
        .TIMEOUT_CYCLES   (c_to),
        .ADDR_WIDTH       (32),
        .DATA_WIDTH       (32),
        .CYCLE_WIDTH      (32),
        .TOHOST_ADDR      (c_tohost)
    ) dut (
        .CLK              (CLK),
        .reset            (reset),
        .start            (start),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .core_clk_en      (core_clk_en),
        .core_reset       (core_reset),
        .cycle_count      (cycle_count),
        .done             (done),
        .pass             (pass),
        .fail             (fail),
        .timeout          (timeout),
        .exit_code        (exit_code)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Rising edges sit at 10k+5, so a falling edge at 10k+10 follows edge k.
    function automatic int edge_idx();
        return int'(($time - 64'd10) / 64'd10);
    endfunction

    function automatic exp_t model_exit(input logic [31:0] d, input int cycles_before);
        exp_t e;
        e.code    = d >> 1;
        e.pass    = (e.code == 32'd0);
        e.fail    = (e.code != 32'd0);
        e.timeout = 1'b0;
        e.cycles  = 32'(cycles_before + 1);
        return e;
    endfunction

    task automatic wait_level(input int sel, input logic val, input string tag, output int k);
        logic cur;
        bit   ok = 1'b0;
        k = -1;
        for (int i = 0; i < c_limit; i++) begin
            @(negedge CLK);
            case (sel)
                0:       cur = core_clk_en;
                1:       cur = core_reset;
                default: cur = done;
            endcase
            if (cur === val) begin
                ok = 1'b1;
                k  = edge_idx();
                break;
            end
        end
        check({tag, "_reached"}, 64'(ok), 64'd1);
    endtask

    task automatic wait_tick(input int target, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < c_limit; i++) begin
            @(negedge CLK);
            if (core_clk_en === 1'b1 && cycle_count === 32'(target)) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 64'(ok), 64'd1);
    endtask

    // Called on a falling edge; holds the store across exactly one rising edge.
    task automatic store(input logic [31:0] a, input logic [31:0] d,
                         input bit on_tick, input int cycles_before);
        if (on_tick && a == c_tohost && d[0])
            exp_q.push_back(model_exit(d, cycles_before));
        mem_write_enable = 1'b1;
        mem_address      = a;
        mem_write_data   = d;
        @(posedge CLK);
        #1;
        mem_write_enable = 1'b0;
        mem_address      = '0;
        mem_write_data   = '0;
    endtask

    task automatic do_start(output int n);
        @(negedge CLK);
        start = 1'b1;
        @(posedge CLK);
        n = int'(($time - 64'd5) / 64'd10);
        #1;
        start = 1'b0;
    endtask

    task automatic check_done(input string tag);
        int   k;
        exp_t e;
        wait_level(2, 1'b1, {tag, "_done"}, k);
        check({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_pass"},    64'(pass),        64'(e.pass));
            check({tag, "_fail"},    64'(fail),        64'(e.fail));
            check({tag, "_timeout"}, 64'(timeout),     64'(e.timeout));
            check({tag, "_code"},    64'(exit_code),   64'(e.code));
            check({tag, "_cycles"},  64'(cycle_count), 64'(e.cycles));
        end
    endtask

    task automatic check_frozen(input string tag);
        int hi = 0;
        repeat (3 * c_div) begin
            @(negedge CLK);
            if (core_clk_en !== 1'b0) hi++;
        end
        check({tag, "_no_tick"},    64'(hi),         64'd0);
        check({tag, "_core_reset"}, 64'(core_reset), 64'd0);
        check({tag, "_done_held"},  64'(done),       64'd1);
    endtask

    initial begin
        int n;
        int k;
        int k2;
        int hi;

        reset            = 1'b1;
        start            = 1'b0;
        mem_write_enable = 1'b0;
        mem_address      = '0;
        mem_write_data   = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_core_reset", 64'(core_reset),  64'd1);
        check("rst_clk_en",     64'(core_clk_en), 64'd0);
        check("rst_cycles",     64'(cycle_count), 64'd0);
        check("rst_done",       64'(done),        64'd0);
        check("rst_pass",       64'(pass),        64'd0);
        check("rst_fail",       64'(fail),        64'd0);
        check("rst_timeout",    64'(timeout),     64'd0);
        check("rst_code",       64'(exit_code),   64'd0);
        reset = 1'b0;

        // Run A: sequencing timing, console write ignored, then a passing exit.
        do_start(n);
        wait_level(0, 1'b1, "a_first_en", k);
        check("a_first_en_offset", 64'(k - n), 64'(c_div));
        wait_level(0, 1'b0, "a_en_low", k2);
        wait_level(0, 1'b1, "a_second_en", k2);
        check("a_en_period", 64'(k2 - k), 64'(c_div));
        wait_level(1, 1'b0, "a_rst_fall", k);
        check("a_rst_fall_offset", 64'(k - n), 64'(c_div * c_rst));
        @(negedge CLK);
        check("a_first_run_tick", 64'(cycle_count), 64'd1);
        repeat (c_div) @(negedge CLK);
        check("a_second_run_tick", 64'(cycle_count), 64'd2);
        wait_tick(3, "a_tick3");
        store(c_tohost, 32'h6, 1'b1, 3);
        @(negedge CLK);
        check("a_console_ignored", 64'(done), 64'd0);
        wait_tick(5, "a_tick5");
        store(c_tohost, 32'h1, 1'b1, 5);
        check_done("a");
        check_frozen("a");

        // Run B: restart from DONE, console write, then failing exit code 3.
        do_start(n);
        check("b_clr_done",       64'(done),        64'd0);
        check("b_clr_pass",       64'(pass),        64'd0);
        check("b_clr_code",       64'(exit_code),   64'd0);
        check("b_clr_cycles",     64'(cycle_count), 64'd0);
        check("b_clr_core_reset", 64'(core_reset),  64'd1);
        wait_tick(2, "b_tick2");
        store(c_tohost, 32'h6, 1'b1, 2);
        wait_tick(4, "b_tick4");
        store(c_tohost, 32'h7, 1'b1, 4);
        check_done("b");

        // Run C: no exit write, so the run times out.
        do_start(n);
        exp_q.push_back('{pass: 1'b0, fail: 1'b0, timeout: 1'b1, code: 32'd0, cycles: 32'(c_to)});
        check_done("c");
        check_frozen("c");

        // Run D: off-tick store ignored, exit on the final tick beats timeout.
        do_start(n);
        wait_tick(50, "d_tick50");
        wait_level(0, 1'b0, "d_off_tick", k);
        store(c_tohost, 32'h1, 1'b0, 0);
        @(negedge CLK);
        check("d_off_tick_ignored", 64'(done), 64'd0);
        wait_tick(c_to - 1, "d_tick_last");
        store(c_tohost, 32'h1, 1'b1, c_to - 1);
        check_done("d");

        // Run E: reset in the middle of a run.
        do_start(n);
        wait_tick(10, "e_tick10");
        reset = 1'b1;
        @(posedge CLK);
        #1;
        check("e_rst_core_reset", 64'(core_reset),  64'd1);
        check("e_rst_clk_en",     64'(core_clk_en), 64'd0);
        check("e_rst_cycles",     64'(cycle_count), 64'd0);
        check("e_rst_done",       64'(done),        64'd0);
        @(negedge CLK);
        reset = 1'b0;
        hi = 0;
        repeat (3 * c_div) begin
            @(negedge CLK);
            if (core_clk_en !== 1'b0) hi++;
        end
        check("e_idle_no_tick", 64'(hi), 64'd0);
        check("e_idle_core_reset", 64'(core_reset), 64'd1);

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
